// File: rtl/time_set_controller.sv
// Front-panel setting controller: debounces three buttons, steps the field-select mode and
// issues inc/dec requests stretched so the 1 Hz counter chain samples each exactly once.
`timescale 1ns / 1ps

module time_set_controller #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned IDLE_TIMEOUT_S  = 30
) (
  input  logic       clk_50MHz,
  input  logic       rst_n,
  input  logic       clk_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       set_sec,
  output logic       set_min,
  output logic       set_hour,
  output logic       set_day,
  output logic       set_month,
  output logic       set_year,
  output logic       inc,
  output logic       dec,
  output logic [2:0] mode,
  output logic       setting_active
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned ToW = $clog2(IDLE_TIMEOUT_S + 1);
  localparam logic [DbW-1:0] DbLoad = DbW'(DEBOUNCE_CYCLES);
  localparam logic [ToW-1:0] ToLast = ToW'(IDLE_TIMEOUT_S - 1);

  typedef enum logic [2:0] {
    ModeRun   = 3'd0,
    ModeSec   = 3'd1,
    ModeMin   = 3'd2,
    ModeHour  = 3'd3,
    ModeDay   = 3'd4,
    ModeMonth = 3'd5,
    ModeYear  = 3'd6
  } mode_e;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLow,
    StWaitRise
  } req_state_e;

  // Bit 0 = mode, bit 1 = up, bit 2 = down.
  logic [2:0]     btn_raw;
  logic [2:0]     btn_s1_q, btn_s2_q;
  logic           hz_s1_q, hz_s2_q, hz_prev_q;
  logic           hz_rise;

  logic [DbW-1:0] db_cnt_q [3];
  logic [DbW-1:0] db_cnt_d [3];
  logic [2:0]     db_lvl_q, db_lvl_d;
  logic [2:0]     press_q, press_d;

  mode_e          mode_q, mode_d;
  logic [ToW-1:0] to_cnt_q, to_cnt_d;
  logic [5:0]     set_q, set_d;
  logic           active_q, active_d;

  req_state_e     req_q, req_d;
  logic           inc_q, inc_d;
  logic           dec_q, dec_d;

  assign btn_raw = {btn_down, btn_up, btn_mode};
  assign hz_rise = hz_s2_q & ~hz_prev_q;

  // Debounce: the counter is reloaded while the synchronized level matches, and counts down
  // while it differs; an expired count with the level still different accepts the change.
  always_comb begin
    db_lvl_d = db_lvl_q;
    press_d  = 3'b000;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (btn_s2_q[i] == db_lvl_q[i]) begin
        db_cnt_d[i] = DbLoad;
      end else if (db_cnt_q[i] != '0) begin
        db_cnt_d[i] = db_cnt_q[i] - DbW'(1);
      end else begin
        db_lvl_d[i] = btn_s2_q[i];
        press_d[i]  = btn_s2_q[i];
      end
    end
  end

  // Mode stepping and idle timeout; both are frozen while a request is in flight.
  always_comb begin
    mode_d   = mode_q;
    to_cnt_d = to_cnt_q;
    if (req_q == StIdle) begin
      if (press_q[0]) begin
        mode_d = (mode_q == ModeYear) ? ModeRun : mode_e'(mode_q + 3'd1);
      end
      if (|press_q) begin
        to_cnt_d = '0;
      end else if (mode_q != ModeRun && hz_rise) begin
        if (to_cnt_q == ToLast) begin
          mode_d   = ModeRun;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end
    end
    if (mode_d == ModeRun) begin
      to_cnt_d = '0;
    end
  end

  always_comb begin
    set_d    = 6'b000000;
    active_d = (mode_d != ModeRun);
    unique case (mode_d)
      ModeSec:   set_d = 6'b000001;
      ModeMin:   set_d = 6'b000010;
      ModeHour:  set_d = 6'b000100;
      ModeDay:   set_d = 6'b001000;
      ModeMonth: set_d = 6'b010000;
      ModeYear:  set_d = 6'b100000;
      default:   set_d = 6'b000000;
    endcase
  end

  // Request is held through a full clk_1hz low phase and released on the following rise.
  always_comb begin
    req_d = req_q;
    inc_d = inc_q;
    dec_d = dec_q;
    unique case (req_q)
      StIdle: begin
        if (mode_q != ModeRun && (press_q[1] ^ press_q[2])) begin
          inc_d = press_q[1];
          dec_d = press_q[2];
          req_d = StWaitLow;
        end
      end
      StWaitLow: begin
        // A low level covers both a fresh fall and being low already on entry.
        if (!hz_s2_q) begin
          req_d = StWaitRise;
        end
      end
      StWaitRise: begin
        if (hz_rise) begin
          req_d = StIdle;
          inc_d = 1'b0;
          dec_d = 1'b0;
        end
      end
      default: begin
        req_d = StIdle;
        inc_d = 1'b0;
        dec_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1_q  <= 3'b000;
      btn_s2_q  <= 3'b000;
      hz_s1_q   <= 1'b0;
      hz_s2_q   <= 1'b0;
      hz_prev_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= '0;
      end
      db_lvl_q  <= 3'b000;
      press_q   <= 3'b000;
      mode_q    <= ModeRun;
      to_cnt_q  <= '0;
      set_q     <= 6'b000000;
      active_q  <= 1'b0;
      req_q     <= StIdle;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
    end else begin
      btn_s1_q  <= btn_raw;
      btn_s2_q  <= btn_s1_q;
      hz_s1_q   <= clk_1hz;
      hz_s2_q   <= hz_s1_q;
      hz_prev_q <= hz_s2_q;
      for (int i = 0; i < 3; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      db_lvl_q  <= db_lvl_d;
      press_q   <= press_d;
      mode_q    <= mode_d;
      to_cnt_q  <= to_cnt_d;
      set_q     <= set_d;
      active_q  <= active_d;
      req_q     <= req_d;
      inc_q     <= inc_d;
      dec_q     <= dec_d;
    end
  end

  assign mode           = mode_q;
  assign setting_active = active_q;
  assign set_sec        = set_q[0];
  assign set_min        = set_q[1];
  assign set_hour       = set_q[2];
  assign set_day        = set_q[3];
  assign set_month      = set_q[4];
  assign set_year       = set_q[5];
  assign inc            = inc_q;
  assign dec            = dec_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Directed bench for time_set_controller; requests seen by the 1 Hz domain are
// matched against a queue of expected inc/dec events.
`timescale 1ns / 1ps

module tb_time_set_controller;

  logic       clk_50MHz = 1'b0;
  logic       rst_n = 1'b1;
  logic       clk_1hz;
  logic       btn_mode = 1'b0;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       set_sec, set_min, set_hour, set_day, set_month, set_year;
  logic       inc, dec;
  logic [2:0] mode;
  logic       setting_active;
  logic [5:0] set_vec;

  int checks = 0;
  int passes = 0;
  int inc_seen = 0;
  int dec_seen = 0;
  int exp_q[$];  // 2 = inc, 1 = dec

  time_set_controller #(
    .DEBOUNCE_CYCLES(4),
    .IDLE_TIMEOUT_S (3)
  ) dut (
    .clk_50MHz     (clk_50MHz),
    .rst_n         (rst_n),
    .clk_1hz       (clk_1hz),
    .btn_mode      (btn_mode),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .set_sec       (set_sec),
    .set_min       (set_min),
    .set_hour      (set_hour),
    .set_day       (set_day),
    .set_month     (set_month),
    .set_year      (set_year),
    .inc           (inc),
    .dec           (dec),
    .mode          (mode),
    .setting_active(setting_active)
  );

  assign set_vec = {set_year, set_month, set_day, set_hour, set_min, set_sec};

  always #5 clk_50MHz = ~clk_50MHz;

  // 16 cycles high / 16 low, edges placed between clock edges.
  initial begin
    clk_1hz = 1'b0;
    #2;
    forever begin
      clk_1hz = 1'b1;
      #160;
      clk_1hz = 1'b0;
      #160;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] onehot(input int m);
    logic [5:0] v;
    v = 6'b000001;
    if (m == 0) return 6'b000000;
    return v << (m - 1);
  endfunction

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk_50MHz);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    repeat (10) @(negedge clk_50MHz);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (10) @(negedge clk_50MHz);
  endtask

  // The counter chain's view: every clk_1hz rise with a request high is one step.
  always @(posedge clk_1hz) begin
    if (inc || dec) begin
      if (inc) inc_seen++;
      if (dec) dec_seen++;
      if (exp_q.size() == 0) check("unexpected_req", {30'd0, inc, dec}, 32'd0);
      else check("req_kind", {30'd0, inc, dec}, exp_q.pop_front());
    end
  end

  initial begin
    int n;
    #1 rst_n = 1'b0;
    #2;
    check("rst_mode", mode, 0);
    check("rst_set", set_vec, 0);
    check("rst_active", setting_active, 0);
    check("rst_inc", inc, 0);
    check("rst_dec", dec, 0);
    repeat (3) @(negedge clk_50MHz);
    rst_n = 1'b1;
    repeat (4) @(negedge clk_50MHz);

    for (int i = 1; i <= 7; i++) begin
      press(1'b1, 1'b0, 1'b0);
      check("mode_step", mode, i % 7);
      check("set_onehot", set_vec, onehot(i % 7));
      check("active_step", setting_active, (i % 7) != 0);
    end

    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("mode_min", mode, 2);

    // Up press early in a high phase: inc one cycle after the press event.
    @(posedge clk_1hz);
    @(negedge clk_50MHz);
    btn_up = 1'b1;
    exp_q.push_back(2);
    repeat (7) @(negedge clk_50MHz);
    check("inc_early", inc, 0);
    @(negedge clk_50MHz);
    check("inc_rise", inc, 1);
    check("dec_quiet", dec, 0);
    btn_up = 1'b0;
    @(negedge clk_1hz);
    repeat (8) @(negedge clk_50MHz);
    check("inc_low_phase", inc, 1);
    @(posedge clk_1hz);
    @(negedge clk_50MHz);
    @(negedge clk_50MHz);
    check("inc_hold", inc, 1);
    @(negedge clk_50MHz);
    check("inc_fall", inc, 0);
    check("model_count", inc_seen, 1);
    check("queue_drained", exp_q.size(), 0);

    // Idle timeout, restarted by a press event after two rises.
    press(1'b1, 1'b0, 1'b0);
    check("mode_hour", mode, 3);
    @(posedge clk_1hz);
    press(1'b1, 1'b0, 1'b0);
    check("mode_day", mode, 4);
    @(posedge clk_1hz);
    @(posedge clk_1hz);
    repeat (5) @(negedge clk_50MHz);
    check("to_two_rises", mode, 4);
    press(1'b0, 1'b1, 1'b1);
    check("both_inc", inc, 0);
    check("both_dec", dec, 0);
    @(posedge clk_1hz);
    @(posedge clk_1hz);
    repeat (5) @(negedge clk_50MHz);
    check("to_restarted", mode, 4);
    @(posedge clk_1hz);
    repeat (5) @(negedge clk_50MHz);
    check("to_expired", mode, 0);
    check("to_set", set_vec, 0);
    check("to_active", setting_active, 0);

    // RUN: up and down are dropped.
    press(1'b0, 1'b1, 1'b0);
    check("run_up_inc", inc, 0);
    press(1'b0, 1'b0, 1'b1);
    check("run_down_dec", dec, 0);
    repeat (40) @(negedge clk_50MHz);

    // SEC: simultaneous press dropped, mode press dropped under a dec request, glitch ignored.
    press(1'b1, 1'b0, 1'b0);
    check("mode_sec", mode, 1);
    press(1'b0, 1'b1, 1'b1);
    check("simul_inc", inc, 0);
    check("simul_dec", dec, 0);
    @(posedge clk_1hz);
    @(negedge clk_50MHz);
    btn_down = 1'b1;
    exp_q.push_back(1);
    repeat (8) @(negedge clk_50MHz);
    check("dec_rise", dec, 1);
    check("inc_excl", inc, 0);
    btn_down = 1'b0;
    press(1'b1, 1'b0, 1'b0);
    check("mode_locked", mode, 1);
    check("dec_still", dec, 1);
    n = 0;
    while (dec && n < 100) begin
      @(negedge clk_50MHz);
      n++;
    end
    check("dec_drop", dec, 0);
    check("mode_after_dec", mode, 1);
    check("dec_count", dec_seen, 1);
    @(negedge clk_50MHz);
    btn_up = 1'b1;
    repeat (3) @(negedge clk_50MHz);
    btn_up = 1'b0;
    repeat (20) @(negedge clk_50MHz);
    check("glitch_inc", inc, 0);
    check("glitch_mode", mode, 1);

    // Reset during WAIT_RISE with btn_up held through release.
    @(posedge clk_1hz);
    @(negedge clk_50MHz);
    btn_up = 1'b1;
    repeat (8) @(negedge clk_50MHz);
    check("pre_rst_inc", inc, 1);
    @(negedge clk_1hz);
    repeat (5) @(negedge clk_50MHz);
    check("wait_rise_inc", inc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_inc", inc, 0);
    check("arst_dec", dec, 0);
    check("arst_mode", mode, 0);
    check("arst_set", set_vec, 0);
    check("arst_active", setting_active, 0);
    repeat (3) @(negedge clk_50MHz);
    rst_n = 1'b1;
    repeat (40) @(negedge clk_50MHz);
    check("held_up_inc", inc, 0);
    check("held_up_mode", mode, 0);
    btn_up = 1'b0;
    repeat (40) @(negedge clk_50MHz);

    check("final_queue", exp_q.size(), 0);
    check("final_inc", inc_seen, 1);
    check("final_dec", dec_seen, 1);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
